mult_datapath: RTL and testbench

Datapath for the shift-and-add sequential multiplier in projeto2, directly downstream of the control unit FSM.
- Consumes the FSM's command signals: load, clear, add, shift.
- Returns the status signals the FSM branches on: multiplier LSB, multiplier zero, count exhausted.
- Holds operand, accumulator and iteration-counter registers. Exposes the 2*WIDTH-bit product.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_datapath_down_counter.sv | 30 +++
 rtl/mult_datapath.sv | 105 ++++++++++
 tb/tb_mult_datapath.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width default,
// iteration-counter width derivation and the command-vector bit layout that
// the control unit and the datapath both rely on.
package mult_pkg;

    localparam int WIDTH_DEF = 8;

    // Command-vector bit positions (ld > clr_acc > {add_en, shift_en}).
    localparam int CMD_LD    = 0;
    localparam int CMD_CLR   = 1;
    localparam int CMD_ADD   = 2;
    localparam int CMD_SHIFT = 3;
    localparam int CMD_W     = 4;

    // Bits needed to hold an iteration count from 0 up to w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_datapath_down_counter.sv
// Loadable down-counter that saturates at zero; used for the iteration count.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count register: load wins, otherwise decrement only while non-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec_en && (r_count != '0)) begin
            r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mult_datapath.sv
// Datapath of the sequential shift-and-add multiplier. Executes load / clear /
// add / shift commands from the control FSM and reports the status bits it
// branches on. All outputs are derived from registers only.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               ld,
    input  logic               clr_acc,
    input  logic               add_en,
    input  logic               shift_en,
    output logic               b_lsb,
    output logic               b_zero,
    output logic               cnt_zero,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;

    logic [CMD_W-1:0]   w_cmd;
    logic               w_cnt_zero;
    logic               w_do_ld;
    logic               w_do_clr;
    logic               w_do_add;
    logic               w_do_shift;

    assign w_cmd[CMD_LD]    = ld;
    assign w_cmd[CMD_CLR]   = clr_acc;
    assign w_cmd[CMD_ADD]   = add_en;
    assign w_cmd[CMD_SHIFT] = shift_en;

    // Command decode: ld masks everything, clr_acc masks add/shift, and
    // add/shift are dropped once the iteration count is exhausted.
    always_comb begin
        w_do_ld    = 1'b0;
        w_do_clr   = 1'b0;
        w_do_add   = 1'b0;
        w_do_shift = 1'b0;
        if (w_cmd[CMD_LD]) begin
            w_do_ld = 1'b1;
        end else if (w_cmd[CMD_CLR]) begin
            w_do_clr = 1'b1;
        end else if (!w_cnt_zero) begin
            w_do_add   = w_cmd[CMD_ADD];
            w_do_shift = w_cmd[CMD_SHIFT];
        end else begin
            w_do_add   = 1'b0;
            w_do_shift = 1'b0;
        end
    end

    // Operand and accumulator registers; the add always sees pre-shift A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_p <= '0;
        end else if (w_do_ld) begin
            r_a <= {{WIDTH{1'b0}}, a_in};
            r_b <= b_in;
            r_p <= '0;
        end else begin
            if (w_do_clr) begin
                r_p <= '0;
            end else if (w_do_add) begin
                r_p <= r_p + r_a;
            end else begin
                r_p <= r_p;
            end
            if (w_do_shift) begin
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
            end else begin
                r_a <= r_a;
                r_b <= r_b;
            end
        end
    end

    down_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_do_ld),
        .i_load_val (CNT_W'(WIDTH)),
        .i_dec_en   (w_do_shift),
        .o_zero     (w_cnt_zero)
    );

    assign b_lsb    = r_b[0];
    assign b_zero   = (r_b == '0);
    assign cnt_zero = w_cnt_zero;
    assign product  = r_p;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed and randomized bench for mult_datapath (WIDTH = 8) with an
// arithmetic reference model of the A/B/P/count registers.
module tb_mult_datapath;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           ld;
    logic           clr_acc;
    logic           add_en;
    logic           shift_en;
    logic           b_lsb;
    logic           b_zero;
    logic           cnt_zero;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    // Reference state as plain integers.
    int unsigned m_a, m_b, m_p, m_c;

    mult_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .ld(ld), .clr_acc(clr_acc), .add_en(add_en), .shift_en(shift_en),
        .b_lsb(b_lsb), .b_zero(b_zero), .cnt_zero(cnt_zero), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_p = 0; m_c = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".product"},  {16'h0, product}, m_p);
        chk({tag, ".b_lsb"},    {31'h0, b_lsb},    m_b & 1);
        chk({tag, ".b_zero"},   {31'h0, b_zero},   (m_b == 0) ? 32'd1 : 32'd0);
        chk({tag, ".cnt_zero"}, {31'h0, cnt_zero}, (m_c == 0) ? 32'd1 : 32'd0);
    endtask

    // One clock with the given commands; the model follows the multiplier rules.
    task automatic step(input string tag, input logic l, input logic c,
                        input logic ad, input logic sh,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned old_a;
        ld = l; clr_acc = c; add_en = ad; shift_en = sh; a_in = a; b_in = b;
        @(posedge clk);
        if (l) begin
            m_a = a; m_b = b; m_p = 0; m_c = W;
        end else if (c) begin
            m_p = 0;
        end else if (m_c != 0) begin
            old_a = m_a;
            if (ad) m_p = (m_p + old_a) % 65536;
            if (sh) begin
                m_a = (old_a * 2) % 65536;
                m_b = m_b / 2;
                m_c = m_c - 1;
            end
        end
        #1;
        ld = 1'b0; clr_acc = 1'b0; add_en = 1'b0; shift_en = 1'b0;
        check_all(tag);
    endtask

    // Load then run n iterations of add=B[0] with shift, as the FSM would.
    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        step({tag, ".ld"}, 1'b1, 1'b0, 1'b0, 1'b0, a, b);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'b0, logic'(m_b & 1), 1'b1, 8'h00, 8'h00);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b0; ld = 1'b0; clr_acc = 1'b0; add_en = 1'b0; shift_en = 1'b0;
        a_in = '0; b_in = '0;

        // Reset asserted mid-clock takes effect immediately.
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all("reset_idle");

        // Basic 5*3: b_zero after 2nd shift, cnt_zero exactly 9 edges after ld.
        step("basic.ld", 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd3);
        for (int i = 1; i <= 8; i++) begin
            step("basic", 1'b0, 1'b0, logic'(m_b & 1), 1'b1, 8'h00, 8'h00);
            if (i == 2) chk("basic.b_zero_2nd", {31'h0, b_zero}, 32'd1);
            if (i == 7) chk("basic.cnt_not_yet", {31'h0, cnt_zero}, 32'd0);
        end
        chk("basic.cnt_zero_9", {31'h0, cnt_zero}, 32'd1);
        chk("basic.product", {16'h0, product}, 32'd15);

        // Guard: exhausted count makes add/shift no-ops.
        step("guard", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        chk("guard.product", {16'h0, product}, 32'd15);

        // Max operands.
        run("max", 8'd255, 8'd255, 8);
        chk("max.product", {16'h0, product}, 32'hFE01);

        // Same-cycle add+shift uses pre-shift A; the next add shows A doubled.
        step("same.ld", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd1);
        step("same.as", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        chk("same.p3", {16'h0, product}, 32'd3);
        chk("same.b0", {31'h0, b_zero}, 32'd1);
        step("same.add", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("same.a6", {16'h0, product}, 32'd9);

        // clr_acc beats add/shift and holds A/B/count.
        step("clr", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        chk("clr.product", {16'h0, product}, 32'd0);

        // ld with clr_acc and add_en: only the load happens.
        step("prio.ld", 1'b1, 1'b1, 1'b1, 1'b1, 8'd9, 8'd6);
        chk("prio.product", {16'h0, product}, 32'd0);
        chk("prio.cnt", {31'h0, cnt_zero}, 32'd0);
        for (int i = 0; i < 8; i++)
            step("prio", 1'b0, 1'b0, logic'(m_b & 1), 1'b1, 8'h00, 8'h00);
        chk("prio.result", {16'h0, product}, 32'd54);

        // Abort: reload mid-product restarts cleanly.
        run("abort1", 8'd7, 8'd9, 3);
        run("abort2", 8'd2, 8'd4, 8);
        chk("abort.result", {16'h0, product}, 32'd8);

        // Async reset in the middle of a product.
        run("rstmid", 8'd7, 8'd9, 2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rstmid.async");
        @(negedge clk); rst = 1'b0;

        // Random full products against plain multiplication.
        for (int k = 0; k < 20; k++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run("rand", ra, rb, 8);
            chk("rand.product", {16'h0, product}, 32'(ra) * 32'(rb));
        end

        // Random command soup: ld rare, clr occasional.
        for (int k = 0; k < 150; k++) begin
            step("soup",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)),
                 W'($urandom), W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
